// File: rtl/recog_frame_sequencer.sv
// -----------------------------------------------------------------------------
// recog_frame_sequencer
// Frame-level controller for the camera digit-recognition pipeline. It drops
// the first frames after start-up, then alternates one PROJECT frame (border
// search) with one RECOG frame (digit classification). After each RECOG frame
// it latches the recognised digits in a PUBLISH cycle. It also counts PROJECT
// frames that end without borders being found.
//
// Optional feature: define RECOG_VOTE_EN to publish a result only after VOTE_N
// identical consecutive results.
//
// Ports:
//   cam_pclk           pixel clock, sole clock
//   rst                synchronous reset, active-high
//   run                sequencing enable, sampled at frame boundaries
//   cam_vsync          camera vsync (cam_pclk domain), active-high
//   project_done_flag  1-cycle pulse from projection: borders found
//   digit_in           recognition result, valid at end of a RECOG frame
//   frame_val          frames valid, gates the pipeline inputs
//   proj_en            projection stage enable
//   recog_en           recognition stage enable
//   digit_out          last published result
//   digit_vld          1-cycle pulse when digit_out updates
//   err_cnt            PROJECT frames without borders, saturating at 255
//   seq_state          debug: 0 WARMUP, 1 ARM, 2 PROJECT, 3 RECOG, 4 PUBLISH
// -----------------------------------------------------------------------------
module recog_frame_sequencer #(
    parameter int unsigned WAIT_FRAME = 10,
    parameter int unsigned DIGIT_W    = 24,
    parameter int unsigned VOTE_N     = 3
) (
    input  logic               cam_pclk,
    input  logic               rst,
    input  logic               run,
    input  logic               cam_vsync,
    input  logic               project_done_flag,
    input  logic [DIGIT_W-1:0] digit_in,
    output logic               frame_val,
    output logic               proj_en,
    output logic               recog_en,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               digit_vld,
    output logic [7:0]         err_cnt,
    output logic [2:0]         seq_state
);

    localparam int unsigned FPS_W   = 4;
    localparam int unsigned MATCH_W = 4;
    localparam logic [7:0]  ERR_MAX = 8'hFF;

    // Counters are 4 bits wide, so both thresholds must fit in 1..15.
    if (WAIT_FRAME < 1 || WAIT_FRAME > 15) begin : g_bad_wait
        $error("WAIT_FRAME must be in 1..15");
    end
    if (VOTE_N < 1 || VOTE_N > 15) begin : g_bad_vote
        $error("VOTE_N must be in 1..15");
    end

    typedef enum logic [2:0] {
        ST_WARMUP  = 3'd0,
        ST_ARM     = 3'd1,
        ST_PROJECT = 3'd2,
        ST_RECOG   = 3'd3,
        ST_PUBLISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               vs_q;
    logic [FPS_W-1:0]   fps_cnt_q, fps_cnt_d;
    logic               frame_val_q, frame_val_d;
    logic               proj_en_q, proj_en_d;
    logic               recog_en_q, recog_en_d;
    logic               done_seen_q, done_seen_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [DIGIT_W-1:0] digit_out_q, digit_out_d;
    logic               digit_vld_q, digit_vld_d;
    logic               fb_c;
    logic               publish_c;

`ifdef RECOG_VOTE_EN
    logic [DIGIT_W-1:0] cand_q, cand_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic               hit_c;
`endif

    // Frame boundary: rising edge of vsync.
    assign fb_c = cam_vsync & ~vs_q;

    // Publish decision for the PUBLISH cycle.
`ifdef RECOG_VOTE_EN
    always_comb begin
        cand_d      = cand_q;
        match_cnt_d = match_cnt_q;
        hit_c       = (digit_in == cand_q);
        publish_c   = 1'b0;
        if (state_q == ST_PUBLISH) begin
            if (hit_c) begin
                match_cnt_d = (match_cnt_q >= MATCH_W'(VOTE_N)) ? MATCH_W'(VOTE_N)
                                                                 : match_cnt_q + MATCH_W'(1);
            end else begin
                cand_d      = digit_in;
                match_cnt_d = MATCH_W'(1);
            end
            // Publish only on the cycle the run length first reaches VOTE_N.
            publish_c = (match_cnt_d == MATCH_W'(VOTE_N)) &&
                        !(hit_c && (match_cnt_q == MATCH_W'(VOTE_N)));
        end
    end
`else
    always_comb begin
        publish_c = (state_q == ST_PUBLISH);
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        fps_cnt_d   = fps_cnt_q;
        frame_val_d = frame_val_q;
        done_seen_d = done_seen_q;
        err_cnt_d   = err_cnt_q;
        digit_out_d = digit_out_q;
        digit_vld_d = 1'b0;

        case (state_q)
            ST_WARMUP: begin
                if (fb_c) begin
                    if (fps_cnt_q < FPS_W'(WAIT_FRAME)) begin
                        fps_cnt_d = fps_cnt_q + FPS_W'(1);
                    end else begin
                        frame_val_d = 1'b1;
                        state_d     = run ? ST_PROJECT : ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (fb_c && run) begin
                    state_d = ST_PROJECT;
                end
            end
            ST_PROJECT: begin
                if (project_done_flag) begin
                    done_seen_d = 1'b1;
                end
                if (fb_c) begin
                    done_seen_d = 1'b0;
                    if (!run) begin
                        state_d = ST_ARM;
                    end else if (done_seen_q || project_done_flag) begin
                        state_d = ST_RECOG;
                    end else if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            ST_RECOG: begin
                if (fb_c) begin
                    state_d = run ? ST_PUBLISH : ST_ARM;
                end
            end
            ST_PUBLISH: begin
                if (publish_c) begin
                    digit_out_d = digit_in;
                    digit_vld_d = 1'b1;
                end
                state_d = run ? ST_PROJECT : ST_ARM;
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase

        if (state_d != ST_PROJECT) begin
            done_seen_d = 1'b0;
        end

        // Enables track the state being entered so they line up with seq_state.
        proj_en_d  = (state_d == ST_PROJECT);
        recog_en_d = (state_d == ST_RECOG);
    end

    // State and output registers.
    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            state_q     <= ST_WARMUP;
            vs_q        <= 1'b0;
            fps_cnt_q   <= '0;
            frame_val_q <= 1'b0;
            proj_en_q   <= 1'b0;
            recog_en_q  <= 1'b0;
            done_seen_q <= 1'b0;
            err_cnt_q   <= '0;
            digit_out_q <= '0;
            digit_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= cam_vsync;
            fps_cnt_q   <= fps_cnt_d;
            frame_val_q <= frame_val_d;
            proj_en_q   <= proj_en_d;
            recog_en_q  <= recog_en_d;
            done_seen_q <= done_seen_d;
            err_cnt_q   <= err_cnt_d;
            digit_out_q <= digit_out_d;
            digit_vld_q <= digit_vld_d;
        end
    end

`ifdef RECOG_VOTE_EN
    // Vote history registers.
    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            cand_q      <= '0;
            match_cnt_q <= '0;
        end else begin
            cand_q      <= cand_d;
            match_cnt_q <= match_cnt_d;
        end
    end
`endif

    assign frame_val = frame_val_q;
    assign proj_en   = proj_en_q;
    assign recog_en  = recog_en_q;
    assign digit_out = digit_out_q;
    assign digit_vld = digit_vld_q;
    assign err_cnt   = err_cnt_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_recog_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_recog_frame_sequencer
// Directed bench for recog_frame_sequencer with WAIT_FRAME=2. Inputs are
// driven 1 ns after the rising edge; outputs are sampled at the same point,
// so each sample shows the registers updated by the preceding edge.
// -----------------------------------------------------------------------------
module tb_recog_frame_sequencer;

    localparam int unsigned DIGIT_W = 24;

    logic               clk;
    logic               rst;
    logic               run;
    logic               cam_vsync;
    logic               project_done_flag;
    logic [DIGIT_W-1:0] digit_in;
    logic               frame_val;
    logic               proj_en;
    logic               recog_en;
    logic [DIGIT_W-1:0] digit_out;
    logic               digit_vld;
    logic [7:0]         err_cnt;
    logic [2:0]         seq_state;

    int n_checks = 0;
    int n_errors = 0;

    recog_frame_sequencer #(
        .WAIT_FRAME(2),
        .DIGIT_W   (DIGIT_W),
        .VOTE_N    (3)
    ) dut (
        .cam_pclk         (clk),
        .rst              (rst),
        .run              (run),
        .cam_vsync        (cam_vsync),
        .project_done_flag(project_done_flag),
        .digit_in         (digit_in),
        .frame_val        (frame_val),
        .proj_en          (proj_en),
        .recog_en         (recog_en),
        .digit_out        (digit_out),
        .digit_vld        (digit_vld),
        .err_cnt          (err_cnt),
        .seq_state        (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One-cycle vsync high; returns one cycle after the frame-boundary edge.
    task automatic fb_pulse(input logic done_at_fb);
        cam_vsync         = 1'b1;
        project_done_flag = done_at_fb;
        tick();
        cam_vsync         = 1'b0;
        project_done_flag = 1'b0;
    endtask

    task automatic done_pulse();
        project_done_flag = 1'b1;
        tick();
        project_done_flag = 1'b0;
    endtask

    logic [DIGIT_W-1:0] seq_vals [6];
    logic [DIGIT_W-1:0] exp_out;
    logic               exp_vld;
    int                 vld_total;

    initial begin
        rst               = 1'b1;
        run               = 1'b0;
        cam_vsync         = 1'b0;
        project_done_flag = 1'b0;
        digit_in          = '0;
        #1;
        idle(2);
        rst = 1'b0;

        // Reset state
        check_eq("rst_state", 32'(seq_state), 32'd0);
        check_eq("rst_frame_val", 32'(frame_val), 32'd0);
        check_eq("rst_enables", {30'd0, proj_en, recog_en}, 32'd0);
        check_eq("rst_err", 32'(err_cnt), 32'd0);
        check_eq("rst_digit", 32'(digit_out), 32'd0);
        check_eq("rst_vld", 32'(digit_vld), 32'd0);

        // Warm-up: WAIT_FRAME+1 boundaries before frame_val
        run = 1'b1;
        idle(3);
        fb_pulse(1'b0);
        idle(4);
        fb_pulse(1'b0);
        check_eq("warm_fv_fb2", 32'(frame_val), 32'd0);
        check_eq("warm_state_fb2", 32'(seq_state), 32'd0);
        idle(4);
        fb_pulse(1'b0);
        check_eq("warm_fv_fb3", 32'(frame_val), 32'd1);
        check_eq("warm_state_fb3", 32'(seq_state), 32'd2);
        tick();
        check_eq("warm_proj_en", 32'(proj_en), 32'd1);

        // PROJECT with mid-frame done -> RECOG -> PUBLISH
        idle(3);
        done_pulse();
        idle(3);
        fb_pulse(1'b0);
        check_eq("t2_state_recog", 32'(seq_state), 32'd3);
        check_eq("t2_enables", {30'd0, proj_en, recog_en}, 32'd1);
        check_eq("t2_err", 32'(err_cnt), 32'd0);
        digit_in = 24'h001234;
        idle(3);
        fb_pulse(1'b0);
        check_eq("t2_state_pub", 32'(seq_state), 32'd4);
        check_eq("t2_enables_pub", {30'd0, proj_en, recog_en}, 32'd0);
        check_eq("t2_vld_pub", 32'(digit_vld), 32'd0);
        tick();
        check_eq("t2_state_proj", 32'(seq_state), 32'd2);
        check_eq("t2_proj_en", 32'(proj_en), 32'd1);
`ifdef RECOG_VOTE_EN
        check_eq("t2_vld", 32'(digit_vld), 32'd0);
        check_eq("t2_digit", 32'(digit_out), 32'd0);
`else
        check_eq("t2_vld", 32'(digit_vld), 32'd1);
        check_eq("t2_digit", 32'(digit_out), 32'h001234);
`endif
        tick();
        check_eq("t2_vld_drop", 32'(digit_vld), 32'd0);

        // PROJECT frame without done -> retry, err_cnt 1
        idle(3);
        fb_pulse(1'b0);
        check_eq("t3_err1", 32'(err_cnt), 32'd1);
        check_eq("t3_state", 32'(seq_state), 32'd2);

        // done in the same cycle as FB -> RECOG, err_cnt unchanged
        idle(3);
        fb_pulse(1'b1);
        check_eq("t4_state", 32'(seq_state), 32'd3);
        check_eq("t4_err", 32'(err_cnt), 32'd1);

        // run=0 during RECOG -> ARM, no publish
        run = 1'b0;
        idle(3);
        fb_pulse(1'b0);
        check_eq("t5_state_arm", 32'(seq_state), 32'd1);
        check_eq("t5_enables", {30'd0, proj_en, recog_en}, 32'd0);
        tick();
        check_eq("t5_no_vld", 32'(digit_vld), 32'd0);
        run = 1'b1;
        idle(3);
        fb_pulse(1'b0);
        check_eq("t5_rearm", 32'(seq_state), 32'd2);
        check_eq("t5_rearm_proj", 32'(proj_en), 32'd1);

        // 299 more failing PROJECT frames -> saturate at 255
        for (int i = 0; i < 299; i++) begin
            idle(1);
            fb_pulse(1'b0);
        end
        check_eq("t3_err_sat", 32'(err_cnt), 32'd255);
        check_eq("t3_state_sat", 32'(seq_state), 32'd2);

        // Publish sequence A,A,B,B,B,B
        seq_vals[0] = 24'h000111;
        seq_vals[1] = 24'h000111;
        seq_vals[2] = 24'h000222;
        seq_vals[3] = 24'h000222;
        seq_vals[4] = 24'h000222;
        seq_vals[5] = 24'h000222;
        vld_total   = 0;
`ifdef RECOG_VOTE_EN
        exp_out = '0;
`else
        exp_out = 24'h001234;
`endif
        for (int i = 0; i < 6; i++) begin
            idle(2);
            done_pulse();
            idle(2);
            fb_pulse(1'b0);
            digit_in = seq_vals[i];
            idle(3);
            fb_pulse(1'b0);
            tick();
`ifdef RECOG_VOTE_EN
            exp_vld = (i == 4);
`else
            exp_vld = 1'b1;
`endif
            if (exp_vld) exp_out = seq_vals[i];
            check_eq($sformatf("t6_vld_%0d", i), 32'(digit_vld), 32'(exp_vld));
            check_eq($sformatf("t6_digit_%0d", i), 32'(digit_out), 32'(exp_out));
            if (digit_vld) vld_total++;
        end
`ifdef RECOG_VOTE_EN
        check_eq("t6_vld_total", 32'(vld_total), 32'd1);
`else
        check_eq("t6_vld_total", 32'(vld_total), 32'd6);
`endif
        check_eq("t6_err_hold", 32'(err_cnt), 32'd255);

        // Reset during PROJECT
        idle(3);
        check_eq("t5_pre_rst_state", 32'(seq_state), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_rst_state", 32'(seq_state), 32'd0);
        check_eq("t5_rst_fv", 32'(frame_val), 32'd0);
        check_eq("t5_rst_enables", {30'd0, proj_en, recog_en}, 32'd0);
        check_eq("t5_rst_err", 32'(err_cnt), 32'd0);
        check_eq("t5_rst_digit", 32'(digit_out), 32'd0);
        check_eq("t5_rst_vld", 32'(digit_vld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
